// File: rtl/mcu_bus_initiator.sv
// ---------------------------------------------------------------------------
// mcu_bus_initiator
//
// MCU-side initiator for the FPGA ECC bridge. It converts a valid/ready
// request stream into sequenced write and read cycles on the shared 16-bit
// MCU-FPGA bus. It drives the bridge controls and handles tristate
// turnaround so that the initiator and the bridge never drive the bus at
// the same time.
//
// Parameters:
//   WR_CYCLES    cycles the write data is driven (>= 1)
//   RD_WAIT      cycles the read controls are held before sampling (>= 1)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active-high
//   req_valid    request present
//   req_ready    initiator can accept a request (IDLE only)
//   req_write    1 = write, 0 = read
//   req_data     write data, latched at accept
//   req_ecc_sel  ECC mode for this transaction, latched at accept
//   rsp_valid    one-cycle pulse at transaction completion
//   rsp_write    type of the completed transaction
//   rsp_data     read data, holds its last value otherwise
//   mcu_data_io  bidirectional bus to the bridge
//   write_en     bridge direction control
//   chip_sel     bridge chip select
//   ecc_sel      bridge ECC mode
// ---------------------------------------------------------------------------
module mcu_bus_initiator #(
    parameter int WR_CYCLES = 2,
    parameter int RD_WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_ecc_sel,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [15:0] rsp_data,
    inout  wire  [15:0] mcu_data_io,
    output logic        write_en,
    output logic [1:0]  chip_sel,
    output logic [1:0]  ecc_sel
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_DRIVE,
        W_RELEASE,
        R_SETUP,
        R_DONE
    } state_t;

    localparam int MAX_CYC = (WR_CYCLES > RD_WAIT) ? WR_CYCLES : RD_WAIT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Chip-select encodings seen by the bridge.
    localparam logic [1:0] CS_IDLE   = 2'b11;
    localparam logic [1:0] CS_ACTIVE = 2'b00;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             oe;
    logic             ready_q;
    logic             write_q;
    logic [15:0]      data_q;

    // req_ready is registered, but it is held low while reset is asserted so
    // that nothing looks acceptable until the initiator is actually running.
    assign req_ready = ready_q & ~rst;

    // The bus is driven only in W_DRIVE with oe set. Qualifying with the
    // state as well as oe keeps the bus released if the two ever disagree.
    assign mcu_data_io = (oe && (state == W_DRIVE)) ? data_q : 16'bz;

    // Single sequencer. Every control output is registered and updated on
    // the same edge as the state, so the value written on a transition is
    // the value seen during the new state. The down-counter is loaded on
    // entry to W_DRIVE / R_SETUP and the state is left when it reaches one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            oe        <= 1'b0;
            ready_q   <= 1'b1;
            write_q   <= 1'b0;
            data_q    <= 16'h0000;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_data  <= 16'h0000;
            write_en  <= 1'b1;
            chip_sel  <= CS_IDLE;
            ecc_sel   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    oe        <= 1'b0;
                    if (req_valid && req_ready) begin
                        data_q   <= req_data;
                        write_q  <= req_write;
                        ecc_sel  <= req_ecc_sel;
                        ready_q  <= 1'b0;
                        chip_sel <= CS_ACTIVE;
                        if (req_write) begin
                            // Turnaround cycle: the bridge sees the write
                            // encoding and releases before we drive.
                            write_en <= 1'b0;
                            state    <= W_SETUP;
                        end else begin
                            write_en <= 1'b1;
                            cnt      <= RD_LOAD;
                            state    <= R_SETUP;
                        end
                    end
                end

                W_SETUP: begin
                    oe    <= 1'b1;
                    cnt   <= WR_LOAD;
                    state <= W_DRIVE;
                end

                W_DRIVE: begin
                    if (cnt == CNT_ONE) begin
                        // Release the bus one cycle before the controls
                        // return to idle so the bridge cannot collide.
                        oe        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= write_q;
                        state     <= W_RELEASE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                W_RELEASE: begin
                    rsp_valid <= 1'b0;
                    write_en  <= 1'b1;
                    chip_sel  <= CS_IDLE;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end

                R_SETUP: begin
                    if (cnt == CNT_ONE) begin
                        // Whatever is on the bus, including X/Z, is passed
                        // through untouched.
                        rsp_data  <= mcu_data_io;
                        rsp_valid <= 1'b1;
                        rsp_write <= write_q;
                        chip_sel  <= CS_IDLE;
                        write_en  <= 1'b1;
                        state     <= R_DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                R_DONE: begin
                    rsp_valid <= 1'b0;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    oe        <= 1'b0;
                    rsp_valid <= 1'b0;
                    ready_q   <= 1'b1;
                    write_en  <= 1'b1;
                    chip_sel  <= CS_IDLE;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_mcu_bus_initiator
//
// Directed bench for mcu_bus_initiator. Instance dut_a uses WR_CYCLES=2,
// RD_WAIT=3; instance dut_b uses WR_CYCLES=1, RD_WAIT=1. Each bus has a
// bridge model that drives whenever the bridge direction rule says the
// bridge owns the bus, and a pull-up so a fully released bus reads as
// 16'hFFFF.
// ---------------------------------------------------------------------------
module tb_mcu_bus_initiator;

    logic clk = 1'b0;
    logic rst;

    // dut_a signals
    logic        req_valid_a;
    logic        req_ready_a;
    logic        req_write_a;
    logic [15:0] req_data_a;
    logic [1:0]  req_ecc_sel_a;
    logic        rsp_valid_a;
    logic        rsp_write_a;
    logic [15:0] rsp_data_a;
    tri1  [15:0] bus_a;
    logic        write_en_a;
    logic [1:0]  chip_sel_a;
    logic [1:0]  ecc_sel_a;
    logic [15:0] bridge_val_a;
    logic        bridge_drive_a;

    // dut_b signals
    logic        req_valid_b;
    logic        req_ready_b;
    logic        req_write_b;
    logic [15:0] req_data_b;
    logic [1:0]  req_ecc_sel_b;
    logic        rsp_valid_b;
    logic        rsp_write_b;
    logic [15:0] rsp_data_b;
    tri1  [15:0] bus_b;
    logic        write_en_b;
    logic [1:0]  chip_sel_b;
    logic [1:0]  ecc_sel_b;
    logic [15:0] bridge_val_b;
    logic        bridge_drive_b;

    int tests_run    = 0;
    int tests_failed = 0;
    logic chk_en     = 1'b0;

    always #5 clk = ~clk;

    mcu_bus_initiator #(.WR_CYCLES(2), .RD_WAIT(3)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid_a),
        .req_ready   (req_ready_a),
        .req_write   (req_write_a),
        .req_data    (req_data_a),
        .req_ecc_sel (req_ecc_sel_a),
        .rsp_valid   (rsp_valid_a),
        .rsp_write   (rsp_write_a),
        .rsp_data    (rsp_data_a),
        .mcu_data_io (bus_a),
        .write_en    (write_en_a),
        .chip_sel    (chip_sel_a),
        .ecc_sel     (ecc_sel_a)
    );

    mcu_bus_initiator #(.WR_CYCLES(1), .RD_WAIT(1)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid_b),
        .req_ready   (req_ready_b),
        .req_write   (req_write_b),
        .req_data    (req_data_b),
        .req_ecc_sel (req_ecc_sel_b),
        .rsp_valid   (rsp_valid_b),
        .rsp_write   (rsp_write_b),
        .rsp_data    (rsp_data_b),
        .mcu_data_io (bus_b),
        .write_en    (write_en_b),
        .chip_sel    (chip_sel_b),
        .ecc_sel     (ecc_sel_b)
    );

    // Bridge models: the bridge listens only for write_en=0 with chip_sel
    // not 2'b11, and drives its value in every other combination.
    assign bridge_drive_a = !((write_en_a == 1'b0) && (chip_sel_a != 2'b11));
    assign bridge_drive_b = !((write_en_b == 1'b0) && (chip_sel_b != 2'b11));
    assign bus_a = bridge_drive_a ? bridge_val_a : 16'hzzzz;
    assign bus_b = bridge_drive_b ? bridge_val_b : 16'hzzzz;

    // Whenever the bridge owns a bus, the bus must carry exactly the bridge
    // value; anything else means the initiator is driving at the same time.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            tests_run++;
            if (bridge_drive_a && (bus_a !== bridge_val_a)) begin
                $display("[TB] FAIL bus_contention_a: bus=%h bridge=%h", bus_a, bridge_val_a);
                tests_failed++;
            end
            tests_run++;
            if (bridge_drive_b && (bus_b !== bridge_val_b)) begin
                $display("[TB] FAIL bus_contention_b: bus=%h bridge=%h", bus_b, bridge_val_b);
                tests_failed++;
            end
        end
    end

    // Reset values, then an asynchronous reset in the middle of W_DRIVE.
    task automatic test_reset();
        #2;
        tests_run++;
        if ({write_en_a, chip_sel_a, ecc_sel_a} !== 5'b1_11_00) begin
            $display("[TB] FAIL reset_controls: got %b expected 11100", {write_en_a, chip_sel_a, ecc_sel_a});
            tests_failed++;
        end
        tests_run++;
        if ({rsp_valid_a, rsp_write_a, rsp_data_a} !== 18'h0) begin
            $display("[TB] FAIL reset_rsp: got %b/%b/%h expected 0/0/0000", rsp_valid_a, rsp_write_a, rsp_data_a);
            tests_failed++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready_a !== 1'b1) begin
            $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_a);
            tests_failed++;
        end
        chk_en = 1'b1;
        @(negedge clk);

        bridge_val_a  = 16'h0BAD;
        req_valid_a   = 1'b1;
        req_write_a   = 1'b1;
        req_data_a    = 16'h5A5A;
        req_ecc_sel_a = 2'b01;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus_a !== 16'h5A5A) begin
            $display("[TB] FAIL reset_pre_drive: bus=%h expected 5a5a", bus_a);
            tests_failed++;
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({write_en_a, chip_sel_a, ecc_sel_a} !== 5'b1_11_00) begin
            $display("[TB] FAIL reset_abort_controls: got %b expected 11100", {write_en_a, chip_sel_a, ecc_sel_a});
            tests_failed++;
        end
        tests_run++;
        if (bus_a !== 16'h0BAD) begin
            $display("[TB] FAIL reset_abort_bus: bus=%h expected 0bad", bus_a);
            tests_failed++;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready_a !== 1'b1) begin
            $display("[TB] FAIL reset_abort_ready: got %b expected 1", req_ready_a);
            tests_failed++;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid_a !== 1'b0) begin
                $display("[TB] FAIL reset_abort_no_rsp: cycle %0d rsp_valid=%b expected 0", k, rsp_valid_a);
                tests_failed++;
            end
        end
    endtask

    // Default write: Z in cycle 1, data in cycles 2-3, Z and response in 4.
    task automatic test_write();
        logic [15:0] exp_bus [1:5];
        logic [4:0]  exp_ctl [1:5];
        logic [1:0]  exp_rsp [1:5];
        bridge_val_a = 16'h0F0F;
        exp_bus = '{16'hFFFF, 16'hA5C3, 16'hA5C3, 16'hFFFF, 16'h0F0F};
        // {req_ready, write_en, chip_sel, ecc_sel[1]}
        exp_ctl = '{5'b0_0_00_1, 5'b0_0_00_1, 5'b0_0_00_1, 5'b0_0_00_1, 5'b1_1_11_1};
        exp_rsp = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
        req_valid_a   = 1'b1;
        req_write_a   = 1'b1;
        req_data_a    = 16'hA5C3;
        req_ecc_sel_a = 2'b10;
        tests_run++;
        if (req_ready_a !== 1'b1) begin
            $display("[TB] FAIL write_ready_c0: got %b expected 1", req_ready_a);
            tests_failed++;
        end
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus_a !== exp_bus[k]) begin
                $display("[TB] FAIL write_bus: cycle %0d bus=%h expected %h", k, bus_a, exp_bus[k]);
                tests_failed++;
            end
            tests_run++;
            if ({req_ready_a, write_en_a, chip_sel_a, ecc_sel_a[1]} !== exp_ctl[k] || ecc_sel_a !== 2'b10) begin
                $display("[TB] FAIL write_ctl: cycle %0d got %b ecc=%b expected %b ecc=10", k,
                         {req_ready_a, write_en_a, chip_sel_a, ecc_sel_a[1]}, ecc_sel_a, exp_ctl[k]);
                tests_failed++;
            end
            tests_run++;
            if ({rsp_valid_a, rsp_write_a} !== exp_rsp[k]) begin
                $display("[TB] FAIL write_rsp: cycle %0d got %b expected %b", k, {rsp_valid_a, rsp_write_a}, exp_rsp[k]);
                tests_failed++;
            end
        end
    endtask

    // Read with RD_WAIT=3: response in cycle 4, bridge value returned.
    task automatic test_read();
        logic [2:0] exp_cs_rv [1:5];
        bridge_val_a  = 16'h1234;
        // {chip_sel, rsp_valid}
        exp_cs_rv = '{3'b00_0, 3'b00_0, 3'b00_0, 3'b11_1, 3'b11_0};
        req_valid_a   = 1'b1;
        req_write_a   = 1'b0;
        req_data_a    = 16'hDEAD;
        req_ecc_sel_a = 2'b01;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests_run++;
            if ({chip_sel_a, rsp_valid_a} !== exp_cs_rv[k] || write_en_a !== 1'b1 || ecc_sel_a !== 2'b01) begin
                $display("[TB] FAIL read_ctl: cycle %0d cs/rv=%b we=%b ecc=%b expected %b/1/01", k,
                         {chip_sel_a, rsp_valid_a}, write_en_a, ecc_sel_a, exp_cs_rv[k]);
                tests_failed++;
            end
            tests_run++;
            if (bus_a !== 16'h1234) begin
                $display("[TB] FAIL read_bus: cycle %0d bus=%h expected 1234", k, bus_a);
                tests_failed++;
            end
            if (k == 4) begin
                tests_run++;
                if (rsp_data_a !== 16'h1234 || rsp_write_a !== 1'b0) begin
                    $display("[TB] FAIL read_rsp: data=%h write=%b expected 1234/0", rsp_data_a, rsp_write_a);
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (req_ready_a !== 1'b1 || rsp_data_a !== 16'h1234) begin
            $display("[TB] FAIL read_after: ready=%b data=%h expected 1/1234", req_ready_a, rsp_data_a);
            tests_failed++;
        end
    endtask

    // Write then read with req_valid held: second accept at the edge
    // ending cycle 5, read response in cycle 9.
    task automatic test_back_to_back();
        logic [5:0] exp [1:10];
        bridge_val_a  = 16'h0001;
        // {req_ready, rsp_valid, write_en, chip_sel, rsp_write}
        exp = '{6'b0_0_0_00_0, 6'b0_0_0_00_0, 6'b0_0_0_00_0, 6'b0_1_0_00_1, 6'b1_0_1_11_1,
                6'b0_0_1_00_1, 6'b0_0_1_00_1, 6'b0_0_1_00_1, 6'b0_1_1_11_0, 6'b1_0_1_11_0};
        req_valid_a   = 1'b1;
        req_write_a   = 1'b1;
        req_data_a    = 16'hFFFF;
        req_ecc_sel_a = 2'b11;
        @(posedge clk);
        #1;
        req_write_a   = 1'b0;
        req_data_a    = 16'h0000;
        req_ecc_sel_a = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            tests_run++;
            if ({req_ready_a, rsp_valid_a, write_en_a, chip_sel_a, rsp_write_a} !== exp[k]) begin
                $display("[TB] FAIL b2b_ctl: cycle %0d got %b expected %b", k,
                         {req_ready_a, rsp_valid_a, write_en_a, chip_sel_a, rsp_write_a}, exp[k]);
                tests_failed++;
            end
            if (k == 5) begin
                @(posedge clk);
                #1 req_valid_a = 1'b0;
            end
            if (k == 6) begin
                tests_run++;
                if (ecc_sel_a !== 2'b00) begin
                    $display("[TB] FAIL b2b_ecc: ecc=%b expected 00", ecc_sel_a);
                    tests_failed++;
                end
            end
            if (k == 9) begin
                tests_run++;
                if (rsp_data_a !== 16'h0001) begin
                    $display("[TB] FAIL b2b_read_data: data=%h expected 0001", rsp_data_a);
                    tests_failed++;
                end
            end
        end
    endtask

    // Inputs change while busy; the bus keeps the value latched at accept.
    task automatic test_busy_hold();
        bridge_val_a  = 16'h0F0F;
        req_valid_a   = 1'b1;
        req_write_a   = 1'b1;
        req_data_a    = 16'h1357;
        req_ecc_sel_a = 2'b01;
        @(posedge clk);
        #1;
        req_valid_a   = 1'b0;
        req_data_a    = 16'h2468;
        req_ecc_sel_a = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2 || k == 3) begin
                tests_run++;
                if (bus_a !== 16'h1357) begin
                    $display("[TB] FAIL busy_hold_bus: cycle %0d bus=%h expected 1357", k, bus_a);
                    tests_failed++;
                end
            end
            tests_run++;
            if (ecc_sel_a !== 2'b01) begin
                $display("[TB] FAIL busy_hold_ecc: cycle %0d ecc=%b expected 01", k, ecc_sel_a);
                tests_failed++;
            end
            req_data_a = 16'h9999;
        end
        @(negedge clk);
    endtask

    // WR_CYCLES=1 / RD_WAIT=1: write response in cycle 3, read in cycle 2.
    task automatic test_param_sweep();
        logic [15:0] exp_bus [1:4];
        logic [2:0]  exp_w [1:4];
        logic [2:0]  exp_r [1:3];
        bridge_val_b = 16'h0F0F;
        exp_bus = '{16'hFFFF, 16'h3C3C, 16'hFFFF, 16'h0F0F};
        // {req_ready, rsp_valid, rsp_write}
        exp_w = '{3'b000, 3'b000, 3'b011, 3'b101};
        exp_r = '{3'b001, 3'b010, 3'b100};
        req_valid_b   = 1'b1;
        req_write_b   = 1'b1;
        req_data_b    = 16'h3C3C;
        req_ecc_sel_b = 2'b10;
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus_b !== exp_bus[k] || {req_ready_b, rsp_valid_b, rsp_write_b} !== exp_w[k]) begin
                $display("[TB] FAIL sweep_write: cycle %0d bus=%h flags=%b expected %h/%b", k,
                         bus_b, {req_ready_b, rsp_valid_b, rsp_write_b}, exp_bus[k], exp_w[k]);
                tests_failed++;
            end
        end
        bridge_val_b  = 16'hC0DE;
        req_valid_b   = 1'b1;
        req_write_b   = 1'b0;
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({req_ready_b, rsp_valid_b, rsp_write_b} !== exp_r[k]) begin
                $display("[TB] FAIL sweep_read: cycle %0d flags=%b expected %b", k,
                         {req_ready_b, rsp_valid_b, rsp_write_b}, exp_r[k]);
                tests_failed++;
            end
            if (k == 2) begin
                tests_run++;
                if (rsp_data_b !== 16'hC0DE) begin
                    $display("[TB] FAIL sweep_read_data: data=%h expected c0de", rsp_data_b);
                    tests_failed++;
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        req_valid_a   = 1'b0;
        req_write_a   = 1'b0;
        req_data_a    = 16'h0000;
        req_ecc_sel_a = 2'b00;
        bridge_val_a  = 16'h0F0F;
        req_valid_b   = 1'b0;
        req_write_b   = 1'b0;
        req_data_b    = 16'h0000;
        req_ecc_sel_b = 2'b00;
        bridge_val_b  = 16'h0F0F;

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_hold();
        test_param_sweep();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
